// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// results held in the architectural HI/LO registers, with MTHI/MTLO write access.
module mips_muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] SRC_A,
  input  logic [DATA_WIDTH-1:0] SRC_B,
  input  logic                  HI_WE,
  input  logic                  LO_WE,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mq_q, mq_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic                  div_zero_q, div_zero_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                    is_signed;
  logic [DATA_WIDTH-1:0]   abs_a, abs_b;
  logic [DATA_WIDTH:0]     sum, shifted_rem;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   quot, rem;

  assign is_signed = ~OP[0];
  assign abs_a     = (is_signed && SRC_A[DATA_WIDTH-1]) ? -SRC_A : SRC_A;
  assign abs_b     = (is_signed && SRC_B[DATA_WIDTH-1]) ? -SRC_B : SRC_B;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    b_d         = b_q;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    div_zero_d  = div_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sum         = {1'b0, acc_q[DATA_WIDTH-1:0]} + {1'b0, (mq_q[0] ? b_q : '0)};
    shifted_rem = {acc_q[DATA_WIDTH-1:0], mq_q[DATA_WIDTH-1]};
    prod        = {acc_q[DATA_WIDTH-1:0], mq_q};
    quot        = mq_q;
    rem         = acc_q[DATA_WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (START) begin
          is_div_d   = OP[1];
          neg_d      = is_signed & (SRC_A[DATA_WIDTH-1] ^ SRC_B[DATA_WIDTH-1]);
          rem_neg_d  = is_signed & SRC_A[DATA_WIDTH-1];
          div_zero_d = (SRC_B == '0);
          acc_d      = '0;
          mq_d       = abs_a;
          b_d        = abs_b;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StCalc;
        end else begin
          if (HI_WE) hi_d = WDATA;
          if (LO_WE) lo_d = WDATA;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          // Restoring step: the quotient bit shifts in where the dividend bit left mq.
          if (shifted_rem >= {1'b0, b_q}) begin
            acc_d = shifted_rem - {1'b0, b_q};
            mq_d  = {mq_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted_rem;
            mq_d  = {mq_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, sum[DATA_WIDTH:1]};
          mq_d  = {sum[0], mq_q[DATA_WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          // A zero divisor yields an all-ones quotient; the signed remainder restores SRC_A.
          lo_d = div_zero_q ? '1 : (neg_q ? -quot : quot);
          hi_d = rem_neg_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_q ? -prod : prod;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
